// File: rtl/alu_uart_master.sv
// rtl/alu_uart_master.sv - sequences A, B and opcode bytes to a UART ALU and collects the result byte
module alu_uart_master #(
  parameter int NBIT_DATA_LEN  = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NBIT_DATA_LEN-1:0] a_in,
  input  logic [NBIT_DATA_LEN-1:0] b_in,
  input  logic [5:0]               op_in,
  input  logic                     tx_done_tick,
  input  logic                     rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] tx_data_out,
  output logic                     busy,
  output logic [NBIT_DATA_LEN-1:0] result,
  output logic                     result_valid,
  output logic                     timeout_err
);

  // Wide enough to hold TIMEOUT_CYCLES itself, so the count never wraps.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES
  } state_t;

  state_t                   r_state;
  logic [NBIT_DATA_LEN-1:0] r_a;
  logic [NBIT_DATA_LEN-1:0] r_b;
  logic [5:0]               r_op;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_tx_start;
  logic [NBIT_DATA_LEN-1:0] r_tx_data;
  logic                     r_busy;
  logic [NBIT_DATA_LEN-1:0] r_result;
  logic                     r_result_valid;
  logic                     r_timeout_err;
  logic [NBIT_DATA_LEN-1:0] w_op_byte;

  // Opcode travels as a zero-extended byte.
  assign w_op_byte = NBIT_DATA_LEN'(r_op);

  // Transaction sequencer; every output is loaded together with the state it belongs to,
  // so tx_start is already high in the first cycle of each SEND state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= '0;
      r_cnt          <= '0;
      r_tx_start     <= 1'b0;
      r_tx_data      <= '0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_tx_start     <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_op       <= op_in;
            r_tx_start <= 1'b1;
            r_tx_data  <= a_in;
            r_busy     <= 1'b1;
            r_state    <= SEND_A;
          end
        end
        SEND_A:  r_state <= WAIT_A;
        WAIT_A: begin
          if (tx_done_tick) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= r_b;
            r_state    <= SEND_B;
          end
        end
        SEND_B:  r_state <= WAIT_B;
        WAIT_B: begin
          if (tx_done_tick) begin
            r_tx_start <= 1'b1;
            r_tx_data  <= w_op_byte;
            r_state    <= SEND_OP;
          end
        end
        SEND_OP: r_state <= WAIT_OP;
        WAIT_OP: begin
          if (tx_done_tick) begin
            r_cnt   <= '0;
            r_state <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          // A byte arriving on the expiry cycle still counts as a good result.
          if (rx_done_tick) begin
            r_result       <= rx_data_in;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_data_out  = r_tx_data;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign timeout_err  = r_timeout_err;

endmodule

// File: doc/alu_uart_master.md
ALU_UART_MASTER -- requirements
Module: alu_uart_master

Interface
REQ-001 Parameter NBIT_DATA_LEN, default 8, UART byte width.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, max clk cycles to wait for the result byte.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one ALU transaction; sampled only in IDLE.
REQ-006 a_in, b_in  input  NBIT_DATA_LEN each  operands, latched when start is accepted.
REQ-007 op_in  input  6  opcode, latched when start is accepted.
REQ-008 tx_done_tick  input  1  one-cycle pulse from UART TX: byte fully sent.
REQ-009 rx_done_tick  input  1  one-cycle pulse from UART RX: byte received.
REQ-010 rx_data_in  input  NBIT_DATA_LEN  received byte, valid with rx_done_tick.
REQ-011 tx_start  output  1  one-cycle pulse to UART TX: begin sending tx_data_out.
REQ-012 tx_data_out  output  NBIT_DATA_LEN  byte to transmit.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 result  output  NBIT_DATA_LEN  last ALU result received.
REQ-015 result_valid  output  1  one-cycle pulse: result updated.
REQ-016 timeout_err  output  1  one-cycle pulse: result byte not received in time.

Function
REQ-017 States SHALL be IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES; all outputs registered.
REQ-018 IDLE: start=1 -> latch a_in/b_in/op_in, next state SEND_A; start=0 -> stay.
REQ-019 SEND_x: tx_start=1 and tx_data_out=byte x for exactly that one cycle, then WAIT_x unconditionally.
REQ-020 Bytes sent in order A, B, Op; Op byte = {2'b00, op} (zero-extended to NBIT_DATA_LEN).
REQ-021 tx_data_out SHALL hold the current byte stable from its tx_start cycle until the matching tx_done_tick.
REQ-022 WAIT_A/WAIT_B/WAIT_OP: tx_done_tick -> SEND_B/SEND_OP/WAIT_RES respectively; otherwise stay, no timeout.
REQ-023 rx_done_tick in any state other than WAIT_RES SHALL be ignored (byte discarded, no output change).
REQ-024 WAIT_RES: rx_done_tick -> result<=rx_data_in, result_valid=1 next cycle, state IDLE.
REQ-025 WAIT_RES cycle counter cleared on entry; reaching TIMEOUT_CYCLES without rx_done_tick -> timeout_err=1 one cycle, result unchanged, state IDLE.
REQ-026 rx_done_tick in the same cycle the counter expires: receive wins, no timeout_err.
REQ-027 start while busy SHALL be ignored; operands not re-latched.
REQ-028 Latency: start sampled at edge N -> tx_start high in cycle N+1; tx_done_tick at edge M -> next tx_start in cycle M+1.
REQ-029 result_valid and timeout_err never both high; each high at most one cycle per transaction.
REQ-030 Counter width SHALL hold TIMEOUT_CYCLES without wrap-around.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, tx_start=0, tx_data_out=0, busy=0, result=0, result_valid=0, timeout_err=0, counter=0, latched operands=0.
REQ-032 Reset mid-transaction aborts it; no pulses emitted on release; first start after release begins a new transaction from A.

Verification
REQ-033 start with A=0x05,B=0x03,Op=0x20, TX model ack each byte after 10 cycles, RX returns 0x08 -> bytes 0x05,0x03,0x20 seen, result=0x08, one result_valid pulse, busy falls.
REQ-034 TIMEOUT_CYCLES=16, no RX byte -> timeout_err pulse exactly 16 cycles after WAIT_RES entry, result keeps 0x08.
REQ-035 rx_done_tick with 0xAA while in WAIT_B -> ignored; later result byte 0x11 -> result=0x11.
REQ-036 start pulsed during WAIT_A with different operands -> ignored; bytes sent match first latched values.
REQ-037 rst_n low during WAIT_OP -> all outputs zero asynchronously; after release new start sends A first.
REQ-038 rx_done_tick coincident with timeout expiry (data 0x7F) -> result=0x7F, result_valid=1, timeout_err=0.
